// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: control inputs, fetched word, register operands and the
// PC / status outputs. Optional counters exist under PC_FETCH_PERF_COUNT_EN.
interface pc_fetch_unit_if;
    logic        start;
    logic        stall;
    logic [31:0] instruction;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] pc;
    logic        pc_valid;
    logic        branch_taken;
    logic        halted;
    logic        fault;
`ifdef PC_FETCH_PERF_COUNT_EN
    logic [31:0] retired_count;
    logic [31:0] taken_count;
`endif

    modport master (
        output start, stall, instruction, rs_val, rt_val,
        input  pc, pc_valid, branch_taken, halted, fault
`ifdef PC_FETCH_PERF_COUNT_EN
        , input retired_count, taken_count
`endif
    );

    modport slave (
        input  start, stall, instruction, rs_val, rt_val,
        output pc, pc_valid, branch_taken, halted, fault
`ifdef PC_FETCH_PERF_COUNT_EN
        , output retired_count, taken_count
`endif
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter / next-PC stage: sequential, beq/bne and j flow, with
// start, stall, halt and sticky out-of-range fetch fault.
// Optional retired/taken counters: define PC_FETCH_PERF_COUNT_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 1024,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input logic            clk,
    input logic            rst_n,
    pc_fetch_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        bt_q, bt_d;
    logic        fault_q, fault_d;
    logic [5:0]  opcode;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] next_pc;
    logic        taken;
    logic        consume;
    logic        start_acc;
    logic        is_halt;

    // Decode the presented instruction into a redirect decision and next PC
    always_comb begin
        opcode    = bus.instruction[31:26];
        is_halt   = (bus.instruction == HALT_WORD);
        pc_plus4  = pc_q + 32'd4;
        br_target = pc_plus4 + {{14{bus.instruction[15]}}, bus.instruction[15:0], 2'b00};
        j_target  = {pc_plus4[31:28], bus.instruction[25:0], 2'b00};
        taken     = 1'b0;
        next_pc   = pc_plus4;
        case (opcode)
            OP_BEQ: if (bus.rs_val == bus.rt_val) begin
                taken   = 1'b1;
                next_pc = br_target;
            end
            OP_BNE: if (bus.rs_val != bus.rt_val) begin
                taken   = 1'b1;
                next_pc = br_target;
            end
            OP_J: begin
                taken   = 1'b1;
                next_pc = j_target;
            end
            default: ;
        endcase
    end

    // Next-state, next-PC and status for the IDLE/RUN/HALT flow
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        bt_d      = 1'b0;
        fault_d   = fault_q;
        consume   = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_d   = RUN;
                    pc_d      = RESET_PC;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    consume = 1'b1;
                    if (is_halt) begin
                        state_d = HALT;
                    end else begin
                        bt_d = taken;
                        if (next_pc >= 32'(MEM_BYTES)) begin
                            fault_d = 1'b1;
                            state_d = HALT;
                        end else begin
                            pc_d = next_pc;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            bt_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bt_q    <= bt_d;
            fault_q <= fault_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_valid     = consume;
    assign bus.branch_taken = bt_q;
    assign bus.halted       = (state_q == HALT);
    assign bus.fault        = fault_q;

`ifdef PC_FETCH_PERF_COUNT_EN
    logic [31:0] retired_q;
    logic [31:0] taken_cnt_q;

    // Saturating retired/taken counters, cleared on reset and accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q   <= '0;
            taken_cnt_q <= '0;
        end else if (start_acc) begin
            retired_q   <= '0;
            taken_cnt_q <= '0;
        end else begin
            if (consume && retired_q != '1)
                retired_q <= retired_q + 32'd1;
            if (consume && !is_halt && taken && taken_cnt_q != '1)
                taken_cnt_q <= taken_cnt_q + 32'd1;
        end
    end

    assign bus.retired_count = retired_q;
    assign bus.taken_count   = taken_cnt_q;
`endif

endmodule
